// File: rtl/prime_burst_gen_if.sv
// rtl/prime_burst_gen_if.sv - control and status bundle for prime_burst_gen
interface prime_burst_gen_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 enable;
  logic                 start;
  logic                 prime_seq;
  logic [CNT_WIDTH-1:0] prime_seq_cnt;
  logic [5:0]           cur_prime;
  logic                 busy;
  logic                 seq_done;

  modport master (
    output enable, start,
    input  prime_seq, prime_seq_cnt, cur_prime, busy, seq_done
  );

  modport slave (
    input  enable, start,
    output prime_seq, prime_seq_cnt, cur_prime, busy, seq_done
  );
endinterface

// File: rtl/prime_burst_gen.sv
// rtl/prime_burst_gen.sv - prime-count pulse burst generator with programmable timing
module prime_burst_gen #(
  parameter logic [31:0] PULSE_LEN          = 32'd8339394,
  parameter logic [31:0] INTER_PRIME_GAP    = 32'd16666500,
  parameter logic [31:0] INTER_SEQUENCE_GAP = 32'd33333000,
  parameter int          NUM_PRIMES         = 5,
  parameter int          CNT_WIDTH          = 32,
  parameter bit          CONTINUOUS         = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  prime_burst_gen_if.slave bus
);

  if (NUM_PRIMES < 1 || NUM_PRIMES > 16 || PULSE_LEN == 32'd0 ||
      INTER_PRIME_GAP == 32'd0 || INTER_SEQUENCE_GAP == 32'd0) begin : g_param_check
    $error("prime_burst_gen: illegal parameter value");
  end

  localparam logic [3:0] LAST_PRIME = 4'(NUM_PRIMES - 1);

  typedef enum logic [2:0] {IDLE, PULSE_HI, PULSE_LO, PRIME_GAP, SEQ_GAP} state_t;

  state_t               state, state_nx;
  logic [31:0]          timer, timer_nx;
  logic [5:0]           pulse_idx, pulse_idx_nx;
  logic [3:0]           prime_idx, prime_idx_nx;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_nx;
  logic                 done_nx;
  logic                 seq_q, busy_q, done_q;
  logic [5:0]           cur_q;
  logic                 launch;
  logic                 last_pulse;

  function automatic logic [5:0] prime_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    return 6'd2;
      4'd1:    return 6'd3;
      4'd2:    return 6'd5;
      4'd3:    return 6'd7;
      4'd4:    return 6'd11;
      4'd5:    return 6'd13;
      4'd6:    return 6'd17;
      4'd7:    return 6'd19;
      4'd8:    return 6'd23;
      4'd9:    return 6'd29;
      4'd10:   return 6'd31;
      4'd11:   return 6'd37;
      4'd12:   return 6'd41;
      4'd13:   return 6'd43;
      4'd14:   return 6'd47;
      default: return 6'd53;
    endcase
  endfunction

  assign launch     = CONTINUOUS ? bus.enable : (bus.enable && bus.start);
  assign last_pulse = (pulse_idx == prime_rom(prime_idx) - 6'd1);

  always_comb begin
    state_nx     = state;
    timer_nx     = timer + 32'd1;
    pulse_idx_nx = pulse_idx;
    prime_idx_nx = prime_idx;
    cnt_nx       = cnt_q;
    done_nx      = 1'b0;
    case (state)
      IDLE: begin
        timer_nx = '0;
        if (launch) begin
          state_nx     = PULSE_HI;
          pulse_idx_nx = '0;
          prime_idx_nx = '0;
        end
      end
      PULSE_HI: begin
        if (timer == PULSE_LEN - 32'd1) begin
          timer_nx = '0;
          // The final pulse of a burst skips its low half and goes straight to a gap
          if (!last_pulse) begin
            state_nx = PULSE_LO;
          end else if (prime_idx == LAST_PRIME) begin
            state_nx = SEQ_GAP;
            done_nx  = 1'b1;
            cnt_nx   = cnt_q + CNT_WIDTH'(1);
          end else begin
            state_nx = PRIME_GAP;
          end
        end
      end
      PULSE_LO: begin
        if (timer == PULSE_LEN - 32'd1) begin
          timer_nx     = '0;
          state_nx     = PULSE_HI;
          pulse_idx_nx = pulse_idx + 6'd1;
        end
      end
      PRIME_GAP: begin
        if (timer == INTER_PRIME_GAP - 32'd1) begin
          timer_nx     = '0;
          state_nx     = PULSE_HI;
          pulse_idx_nx = '0;
          prime_idx_nx = prime_idx + 4'd1;
        end
      end
      SEQ_GAP: begin
        if (timer == INTER_SEQUENCE_GAP - 32'd1) begin
          timer_nx     = '0;
          pulse_idx_nx = '0;
          prime_idx_nx = '0;
          state_nx     = (CONTINUOUS && bus.enable) ? PULSE_HI : IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they align with the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      pulse_idx <= '0;
      prime_idx <= '0;
      cnt_q     <= '0;
      seq_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cur_q     <= '0;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      pulse_idx <= pulse_idx_nx;
      prime_idx <= prime_idx_nx;
      cnt_q     <= cnt_nx;
      seq_q     <= (state_nx == PULSE_HI);
      busy_q    <= (state_nx != IDLE);
      done_q    <= done_nx;
      cur_q     <= (state_nx == IDLE) ? 6'd0 : prime_rom(prime_idx_nx);
    end
  end

  assign bus.prime_seq     = seq_q;
  assign bus.prime_seq_cnt = cnt_q;
  assign bus.cur_prime     = cur_q;
  assign bus.busy          = busy_q;
  assign bus.seq_done      = done_q;

endmodule
